// File: rtl/phase_sequencer_pkg.sv
// rtl/phase_sequencer_pkg.sv - shared sizes, default durations and lamp tables for the phase sequencer
package phase_sequencer_pkg;

    localparam int CNT_W  = 6;
    localparam int NPHASE = 10;

    function automatic int def_dur(input int idx);
        case (idx)
            0, 5:    return 15;
            1, 6:    return 4;
            2, 7:    return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [9:0] light_tab(input int idx);
        case (idx)
            0, 1:    return 10'b0010110010;
            2:       return 10'b0011010010;
            3:       return 10'b0101010010;
            4, 9:    return 10'b1001010010;
            5, 6:    return 10'b1001000101;
            7:       return 10'b1001000110;
            8:       return 10'b1001001010;
            default: return 10'b0000000000;
        endcase
    endfunction

    // A phase blinks exactly when its mask is non-zero
    function automatic logic [9:0] blink_mask(input int idx);
        case (idx)
            1:       return 10'b0000100000;
            6:       return 10'b0000000001;
            default: return 10'b0000000000;
        endcase
    endfunction

endpackage

// File: rtl/phase_sequencer_tick.sv
// rtl/phase_sequencer_tick.sv - prescaler producing one tick every TICK_DIV clocks
module tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - timed phase cycle with editable durations, pause, skip and lamp blinking
module phase_sequencer #(
    parameter int CNT_W    = phase_sequencer_pkg::CNT_W,
    parameter int TICK_DIV = 1000,
    parameter int NPHASE   = phase_sequencer_pkg::NPHASE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pause,
    input  logic             skip,
    input  logic             inc,
    input  logic             dec,
    output logic [3:0]       phase,
    output logic [CNT_W-1:0] remain,
    output logic [CNT_W-1:0] dur_cur,
    output logic [9:0]       lights,
    output logic             phase_done
);

    import phase_sequencer_pkg::*;

    localparam logic [CNT_W-1:0] DUR_MAX = '1;
    localparam logic [3:0]       LAST    = 4'(NPHASE - 1);

    logic             tick;
    logic             run;
    logic             adv;
    logic             done_n;
    logic             blink_q;
    logic             blink_n;
    logic [3:0]       nxt;
    logic [3:0]       phase_n;
    logic [CNT_W-1:0] remain_n;
    logic [CNT_W-1:0] dur_edit;
    logic [CNT_W-1:0] dur   [NPHASE];
    logic [CNT_W-1:0] dur_n [NPHASE];

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (skip),
        .tick  (tick)
    );

    always_comb begin
        run      = tick & ~pause;
        adv      = skip | (run & (remain <= CNT_W'(1)));
        nxt      = (phase == LAST) ? 4'd0 : phase + 4'd1;

        dur_edit = dur[phase];
        if (inc && !dec && dur[phase] != DUR_MAX) begin
            dur_edit = dur[phase] + CNT_W'(1);
        end else if (dec && !inc && dur[phase] != '0) begin
            dur_edit = dur[phase] - CNT_W'(1);
        end
        dur_n        = dur;
        dur_n[phase] = dur_edit;

        phase_n  = phase;
        remain_n = remain;
        blink_n  = blink_q;
        done_n   = 1'b0;
        if (adv) begin
            // The edit lands on the old phase; the new phase loads its stored value
            phase_n  = nxt;
            remain_n = dur[nxt];
            blink_n  = 1'b0;
            done_n   = 1'b1;
        end else begin
            if (run) begin
                remain_n = remain - CNT_W'(1);
                if (blink_mask(int'(phase)) != '0) begin
                    blink_n = ~blink_q;
                end
            end
            if (dec && !inc && dur_edit < remain_n) begin
                remain_n = dur_edit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= '0;
            remain     <= CNT_W'(def_dur(0));
            dur_cur    <= CNT_W'(def_dur(0));
            blink_q    <= 1'b0;
            phase_done <= 1'b0;
            lights     <= light_tab(0);
            for (int i = 0; i < NPHASE; i++) begin
                dur[i] <= CNT_W'(def_dur(i));
            end
        end else begin
            phase      <= phase_n;
            remain     <= remain_n;
            dur        <= dur_n;
            blink_q    <= blink_n;
            phase_done <= done_n;
            dur_cur    <= dur_n[phase_n];
            lights     <= light_tab(int'(phase_n)) &
                          ~(blink_n ? blink_mask(int'(phase_n)) : 10'd0);
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - directed table-driven bench for phase_sequencer
module tb_phase_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pause, skip, inc, dec;
    logic [3:0] phase;
    logic [5:0] remain, dur_cur;
    logic [9:0] lights;
    logic       phase_done;

    int total = 0;
    int bad   = 0;

    phase_sequencer #(.CNT_W(6), .TICK_DIV(4), .NPHASE(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pause      (pause),
        .skip       (skip),
        .inc        (inc),
        .dec        (dec),
        .phase      (phase),
        .remain     (remain),
        .dur_cur    (dur_cur),
        .lights     (lights),
        .phase_done (phase_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       p, s, i, d;
        int         n;
        logic [3:0] ph;
        logic [5:0] rem;
        logic [5:0] dur;
        logic [9:0] lts;
        logic       done;
    } vec_t;

    localparam logic [9:0] L0  = 10'b0010110010;
    localparam logic [9:0] L1B = 10'b0010010010;
    localparam logic [9:0] L2  = 10'b0011010010;
    localparam logic [9:0] L3  = 10'b0101010010;
    localparam logic [9:0] L4  = 10'b1001010010;
    localparam logic [9:0] L5  = 10'b1001000101;
    localparam logic [9:0] L6B = 10'b1001000100;
    localparam logic [9:0] L7  = 10'b1001000110;
    localparam logic [9:0] L8  = 10'b1001001010;

    vec_t vt[$];

    function automatic vec_t mk(input logic p, s, i, d, input int n, input logic [3:0] ph,
                                input logic [5:0] rem, dur, input logic [9:0] lts, input logic done);
        vec_t v;
        v.p = p; v.s = s; v.i = i; v.d = d; v.n = n;
        v.ph = ph; v.rem = rem; v.dur = dur; v.lts = lts; v.done = done;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ph, input logic [5:0] rem,
                           input logic [5:0] dur, input logic [9:0] lts, input logic done);
        chk({tag, ".phase"},  32'(phase),      32'(ph));
        chk({tag, ".remain"}, 32'(remain),     32'(rem));
        chk({tag, ".dur"},    32'(dur_cur),    32'(dur));
        chk({tag, ".lights"}, 32'(lights),     32'(lts));
        chk({tag, ".done"},   32'(phase_done), 32'(done));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        //             p s i d   n   ph  rem dur lights done
        vt.push_back(mk(0,0,0,0, 59, 0,  1, 15, L0,  0));
        vt.push_back(mk(0,0,0,0,  1, 1,  4,  4, L0,  1));
        vt.push_back(mk(0,0,0,0,  4, 1,  3,  4, L1B, 0));
        vt.push_back(mk(0,0,0,0,  4, 1,  2,  4, L0,  0));
        vt.push_back(mk(0,0,0,0,  4, 1,  1,  4, L1B, 0));
        vt.push_back(mk(0,0,0,0,  4, 2,  2,  2, L2,  1));
        vt.push_back(mk(0,0,0,1,  1, 2,  1,  1, L2,  0));
        vt.push_back(mk(0,0,0,1,  1, 2,  0,  0, L2,  0));
        vt.push_back(mk(0,0,0,1,  1, 2,  0,  0, L2,  0));
        vt.push_back(mk(0,0,0,0,  1, 3,  1,  1, L3,  1));
        vt.push_back(mk(0,0,0,0,  4, 4,  1,  1, L4,  1));
        vt.push_back(mk(0,0,0,0,  4, 5, 15, 15, L5,  1));
        vt.push_back(mk(1,0,0,0, 40, 5, 15, 15, L5,  0));
        vt.push_back(mk(0,0,0,0,  4, 5, 14, 15, L5,  0));
        vt.push_back(mk(0,1,0,0,  1, 6,  4,  4, L5,  1));
        vt.push_back(mk(0,0,0,0,  3, 6,  4,  4, L5,  0));
        vt.push_back(mk(0,0,0,0,  1, 6,  3,  4, L6B, 0));
        vt.push_back(mk(0,0,1,0,  1, 6,  3,  5, L6B, 0));
        vt.push_back(mk(0,0,1,1,  1, 6,  3,  5, L6B, 0));
        vt.push_back(mk(0,0,0,0,  2, 6,  2,  5, L5,  0));
        vt.push_back(mk(0,0,0,0,  3, 6,  2,  5, L5,  0));
        vt.push_back(mk(0,1,0,0,  1, 7,  2,  2, L7,  1));
        vt.push_back(mk(0,0,0,0,  7, 7,  1,  2, L7,  0));
        vt.push_back(mk(0,0,1,0,  1, 8,  1,  1, L8,  1));
        vt.push_back(mk(0,1,0,0,  1, 9,  1,  1, L4,  1));
        vt.push_back(mk(0,1,0,0,  1, 0, 15, 15, L0,  1));
        vt.push_back(mk(0,0,1,0, 48, 0,  3, 63, L0,  0));
        vt.push_back(mk(0,0,1,0,  1, 0,  3, 63, L0,  0));
        vt.push_back(mk(0,1,1,0,  1, 1,  4,  4, L0,  1));
        vt.push_back(mk(0,1,0,0,  6, 7,  3,  3, L7,  1));
        vt.push_back(mk(0,1,0,0,  3, 0, 63, 63, L0,  1));

        rst_n = 1'b0; pause = 1'b0; skip = 1'b0; inc = 1'b0; dec = 1'b0;
        step(3);
        chk_all("reset", 4'd0, 6'd15, 6'd15, L0, 1'b0);
        rst_n = 1'b1;

        for (int r = 0; r < vt.size(); r++) begin
            pause = vt[r].p; skip = vt[r].s; inc = vt[r].i; dec = vt[r].d;
            step(vt[r].n);
            chk_all($sformatf("row%0d", r), vt[r].ph, vt[r].rem, vt[r].dur, vt[r].lts, vt[r].done);
        end
        pause = 1'b0; skip = 1'b0; inc = 1'b0; dec = 1'b0;

        // Edit phase 7, then reset asynchronously in the middle of a cycle
        skip = 1'b1;
        step(7);
        skip = 1'b0;
        inc  = 1'b1;
        step(1);
        inc  = 1'b0;
        chk_all("pre_rst", 4'd7, 6'd3, 6'd4, L7, 1'b0);
        skip = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 4'd0, 6'd15, 6'd15, L0, 1'b0);
        step(2);
        skip = 1'b0;
        rst_n = 1'b1;
        step(3);
        chk("post_rst.hold", 32'(remain), 32'd15);
        step(1);
        chk("post_rst.first_tick", 32'(remain), 32'd14);
        skip = 1'b1;
        step(7);
        skip = 1'b0;
        chk_all("post_rst.dur7", 4'd7, 6'd2, 6'd2, L7, 1'b1);
        skip = 1'b1;
        step(3);
        skip = 1'b0;
        chk_all("post_rst.dur0", 4'd0, 6'd15, 6'd15, L0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
